cpu_controller: RTL and testbench

- Phase-sequenced control FSM for the VeriRisc CPU; sits directly upstream of the address multiplexer and drives its select (`sel`: 1 = instruction/PC address on `in1`, 0 = operand address on `in0`).
- Contains its own 3-bit phase counter and a halt state.
- Decodes the instruction-register opcode and accumulator zero flag into one control strobe per datapath element (memory, IR, PC, ACC, data bus driver).

---
 rtl/cpu_controller.sv | 136 +++++++++++++
 tb/tb_cpu_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: phase-sequenced control FSM for the VeriRisc CPU.
//   An 8-phase instruction cycle (fetch in phases 0-3, execute in 4-7) plus
//   a HALTED state entered on HLT in phase 4 and left on a `go` request.
//   Control strobes are decoded combinationally from the registered
//   phase/halted state and the current IR opcode / accumulator zero flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   opcode [OP_W]   IR opcode (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7)
//   zero            accumulator-is-zero flag
//   go              resume request, only honoured while halted
//   phase [3]       current phase counter value
//   halted          high while halted
//   sel             address mux select (1 = PC/instruction, 0 = operand)
//   rd, wr          memory read / write enables
//   ld_ir, ld_ac    instruction register / accumulator loads
//   ld_pc, inc_pc   program counter jump load / increment
//   data_e          accumulator-to-data-bus driver enable
// OP_W must be 3: the opcode decode below is only defined for 3-bit opcodes.
module cpu_controller #(
  parameter int          OP_W         = 3,
  parameter logic [2:0]  RESUME_PHASE = 3'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            go,
  output logic [2:0]      phase,
  output logic            halted,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            ld_ac,
  output logic            ld_pc,
  output logic            inc_pc,
  output logic            data_e
);

  localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      if (go) begin
        halted_d = 1'b0;
        phase_d  = RESUME_PHASE;
      end
    end else if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
      // Phase holds at OP_ADDR so the halt is visible where it was detected.
      halted_d = 1'b1;
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  // Output decode
  logic aluop, is_sto, is_jmp, is_skz;
  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_skz = (opcode == OP_SKZ);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    if (!halted_q) begin
      // Fetch phases ignore opcode/zero so an IR update mid-fetch cannot glitch them.
      case (phase_q)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PH_INST_LOAD,
        PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH_OP_ADDR:    inc_pc = 1'b1;
        PH_OP_FETCH:   rd = aluop;
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase  = phase_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero, go;
  logic [2:0] phase;
  logic       halted, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e;

  cpu_controller #(.OP_W(3), .RESUME_PHASE(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .go(go),
    .phase(phase), .halted(halted), .sel(sel), .rd(rd), .wr(wr),
    .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc),
    .data_e(data_e)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, XOR = 3'd4,
                         STO = 3'd6, JMP = 3'd7;

  // Strobe order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e}
  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic       hlt;
    logic [7:0] str;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [11:0] actual();
    return {phase, halted, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e};
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ph=%0d hlt=%b str=%b, want ph=%0d hlt=%b str=%b",
               name, act[11:9], act[8], act[7:0], exp[11:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction's worth of vectors: fetch phases are opcode-independent.
  task automatic add_instr(input logic [2:0] op, input logic z,
                           input logic [7:0] s4, input logic [7:0] s5,
                           input logic [7:0] s6, input logic [7:0] s7);
    logic [7:0] s [8];
    s = '{8'b1000_0000, 8'b1100_0000, 8'b1101_0000, 8'b1101_0000, s4, s5, s6, s7};
    for (int p = 0; p < 8; p++) vecs.push_back('{op, z, 3'(p), 1'b0, s[p]});
  endtask

  initial begin
    rst_n = 1'b0; opcode = ADD; zero = 1'b0; go = 1'b0;

    add_instr(ADD, 1'b0, 8'b0000_0010, 8'b0100_0000, 8'b0100_0000, 8'b0100_1000);
    add_instr(STO, 1'b0, 8'b0000_0010, 8'b0000_0000, 8'b0000_0001, 8'b0010_0001);
    add_instr(SKZ, 1'b1, 8'b0000_0010, 8'b0000_0000, 8'b0000_0010, 8'b0000_0000);
    add_instr(SKZ, 1'b0, 8'b0000_0010, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    add_instr(JMP, 1'b1, 8'b0000_0010, 8'b0000_0000, 8'b0000_0100, 8'b0000_0100);
    add_instr(XOR, 1'b1, 8'b0000_0010, 8'b0100_0000, 8'b0100_0000, 8'b0100_1000);

    #12;
    chk("reset", {3'd0, 1'b0, 8'b1000_0000});
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven run through several instructions, one vector per cycle.
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      go     = (i == 9);  // go during RUN must be ignored
      #1;
      chk($sformatf("vec%0d", i), {vecs[i].ph, vecs[i].hlt, vecs[i].str});
      step();
    end
    go = 1'b0;

    // Halt: fetch, then HLT detected in phase 4 with inc_pc still high.
    opcode = HLT; zero = 1'b0;
    #1;
    chk("hlt_p0", {3'd0, 1'b0, 8'b1000_0000});
    repeat (4) step();
    chk("hlt_p4", {3'd4, 1'b0, 8'b0000_0010});
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("halted%0d", c), {3'd4, 1'b1, 8'b0000_0000});
    end
    go = 1'b1;
    step();
    go = 1'b0;
    chk("resume", {3'd0, 1'b0, 8'b1000_0000});
    opcode = ADD;
    step();
    chk("resume_p1", {3'd1, 1'b0, 8'b1100_0000});

    // Asynchronous reset mid-phase 6 of STO.
    opcode = STO;
    repeat (5) step();
    chk("sto_p6", {3'd6, 1'b0, 8'b0000_0001});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {3'd0, 1'b0, 8'b1000_0000});
    @(negedge clk);
    chk("rst_held", {3'd0, 1'b0, 8'b1000_0000});
    rst_n = 1'b1;
    step();
    chk("rst_restart", {3'd1, 1'b0, 8'b1100_0000});

    // Reset while halted clears halted.
    opcode = HLT;
    repeat (4) step();
    step();
    chk("halt2", {3'd4, 1'b1, 8'b0000_0000});
    #2;
    rst_n = 1'b0; go = 1'b1;
    #1;
    chk("rst_in_halt", {3'd0, 1'b0, 8'b1000_0000});
    @(negedge clk);
    rst_n = 1'b1; go = 1'b0; opcode = ADD;
    step();
    chk("rst_halt_restart", {3'd1, 1'b0, 8'b1100_0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
